alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_exec_unit_if.sv | 48 ++++
 rtl/alu_comb_ops.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-stage ALU. It holds the
//               3-bit ALU control encodings (shared with the ALU decoder),
//               the FSM state encoding and a small op-classification helper.
// Optional    : ALU_FLAGS_EN (used by importers; nothing here depends on it)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control encodings produced by the ALU decoder
  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SUB     = 3'b010;
  localparam logic [2:0] ALU_ILLEGAL = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL     = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  // Execution FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

  // Shifts are the only ops that take the iterative path
  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Request/response bundle for alu_exec_unit.
//               Request : in_valid, in_ready, alu_control, src_a, src_b
//               Response: out_valid, out_ready, result, zero
//               Flags   : negative, carry, overflow (only with ALU_FLAGS_EN)
//               master = requester/consumer side, slave = the ALU.
// Optional    : ALU_FLAGS_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
`ifdef ALU_FLAGS_EN
  logic            negative;
  logic            carry;
  logic            overflow;
`endif

  modport master (
`ifdef ALU_FLAGS_EN
    input  negative, carry, overflow,
`endif
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
`ifdef ALU_FLAGS_EN
    output negative, carry, overflow,
`endif
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface
`default_nettype wire

// File: rtl/alu_comb_ops.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb_ops
// Description : Purely combinational single-cycle ALU operations:
//               ADD, SUB, XOR, OR, AND. Shift and illegal codes return 0.
// Ports       : op_i      ALU control code
//               a_i, b_i  operands
//               res_o     result (modulo 2^XLEN)
//               carry_o   carry-out of ADD / NOT borrow of SUB  (flags only)
//               ovf_o     signed overflow of ADD/SUB            (flags only)
// Optional    : ALU_FLAGS_EN adds carry_o / ovf_o
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
`ifdef ALU_FLAGS_EN
  output logic            carry_o,
  output logic            ovf_o,
`endif
  output logic [XLEN-1:0] res_o
);

  // SUB is done as a + ~b + 1 so one adder serves both ops
  logic            w_sub;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_sum;
  logic            w_addsub;

  assign w_sub    = (op_i == ALU_SUB);
  assign w_addsub = (op_i == ALU_ADD) || w_sub;
  assign w_b      = w_sub ? ~b_i : b_i;

`ifdef ALU_FLAGS_EN
  logic [XLEN:0] w_sum_ext;
  assign w_sum_ext = {1'b0, a_i} + {1'b0, w_b} + {{XLEN{1'b0}}, w_sub};
  assign w_sum     = w_sum_ext[XLEN-1:0];
  assign carry_o   = w_addsub & w_sum_ext[XLEN];
  // Overflow: both adder inputs share a sign that the sum does not
  assign ovf_o     = w_addsub & (a_i[XLEN-1] == w_b[XLEN-1])
                              & (w_sum[XLEN-1] != a_i[XLEN-1]);
`else
  assign w_sum = a_i + w_b + {{(XLEN-1){1'b0}}, w_sub};
`endif

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: res_o = w_sum;
      ALU_XOR:          res_o = a_i ^ b_i;
      ALU_OR:           res_o = a_i | b_i;
      ALU_AND:          res_o = a_i & b_i;
      default:          res_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready on both sides. Single-cycle
//               ops finish one cycle after accept; shifts iterate one bit per
//               cycle (N+1 cycles for shift amount N). Results are held in
//               HOLD until the consumer takes them.
// Ports       : clk    clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    alu_exec_unit_if.slave (request, response, flags)
// Optional    : ALU_FLAGS_EN adds negative/carry/overflow outputs
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_unit_if.slave   bus
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  alu_state_e         state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;   // also the shift working register
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               left_q, left_d;

  logic [XLEN-1:0]    w_comb_res;
  logic [XLEN-1:0]    w_shifted;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt   = bus.src_b[SHAMT_W-1:0];
  assign w_shifted = left_q ? (result_q << 1) : (result_q >> 1);

`ifdef ALU_FLAGS_EN
  logic w_carry, w_ovf;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;

  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .op_i    (bus.alu_control),
    .a_i     (bus.src_a),
    .b_i     (bus.src_b),
    .carry_o (w_carry),
    .ovf_o   (w_ovf),
    .res_o   (w_comb_res)
  );
`else
  alu_comb_ops #(.XLEN(XLEN)) u_comb_ops (
    .op_i    (bus.alu_control),
    .a_i     (bus.src_a),
    .b_i     (bus.src_b),
    .res_o   (w_comb_res)
  );
`endif

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
`ifdef ALU_FLAGS_EN
    carry_d  = carry_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_shift(bus.alu_control)) begin
            result_d = bus.src_a;
            left_d   = (bus.alu_control == ALU_SLL);
            cnt_d    = w_shamt;
`ifdef ALU_FLAGS_EN
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
`endif
            if (w_shamt == '0) begin
              zero_d  = (bus.src_a == '0);
              state_d = HOLD;
            end else begin
              zero_d  = 1'b0;
              state_d = SHIFT;
            end
          end else begin
            result_d = w_comb_res;
            zero_d   = (w_comb_res == '0);
`ifdef ALU_FLAGS_EN
            carry_d  = w_carry;
            ovf_d    = w_ovf;
`endif
            state_d  = HOLD;
          end
        end
      end
      SHIFT: begin
        result_d = w_shifted;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          zero_d  = (w_shifted == '0);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
`ifdef ALU_FLAGS_EN
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
`ifdef ALU_FLAGS_EN
  assign bus.negative  = result_q[XLEN-1];
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit: directed cases plus
//               randomized ops against a behavioural reference model.
// Optional    : ALU_FLAGS_EN also checks negative/carry/overflow
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      3'b000:  return a + b;
      3'b010:  return a - b;
      3'b001:  return a << sh;
      3'b101:  return a >> sh;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    if ((op == 3'b001 || op == 3'b101) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  function automatic logic ref_carry(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (op == 3'b000) return (ua + ub) > 64'sd4294967295;
    if (op == 3'b010) return ua >= ub;   // no borrow
    return 1'b0;
  endfunction

  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'b000)      s = sa + sb;
    else if (op == 3'b010) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // One full transaction: accept, wait for result, optional backpressure,
  // retire. scramble=1 changes operands right after accept.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit scramble);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    bus.out_ready   = 1'b0;
    step();
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.src_a       = $urandom;
      bus.src_b       = $urandom;
      bus.alu_control = 3'($urandom_range(0, 7));
    end
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", bus.result, exp_res);
    check("zero", {31'd0, bus.zero}, {31'd0, exp_res == 32'd0});
    check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
`ifdef ALU_FLAGS_EN
    check("negative", {31'd0, bus.negative}, {31'd0, exp_res[31]});
    check("carry", {31'd0, bus.carry}, {31'd0, ref_carry(op, a, b)});
    check("overflow", {31'd0, bus.overflow}, {31'd0, ref_ovf(op, a, b)});
`endif
    for (int k = 0; k < hold; k++) begin
      bus.in_valid    = 1'b1;
      bus.alu_control = 3'b000;
      bus.src_a       = $urandom;
      bus.src_b       = $urandom;
      step();
      check("hold_result", bus.result, exp_res);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("retire_valid", {31'd0, bus.out_valid}, 32'd0);
    check("retire_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int stale;
    n_vec = 0;
    n_err = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'b000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.out_ready   = 1'b0;
    repeat (3) step();
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Directed cases
    run_op(3'b000, 32'd5, 32'd7, 0, 1'b0);                 // ADD -> 12
    run_op(3'b010, 32'd9, 32'd9, 0, 1'b0);                 // SUB -> 0, zero
    run_op(3'b010, 32'h8000_0000, 32'd1, 0, 1'b0);         // signed overflow
    run_op(3'b000, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);         // wraps to 0, carry
    run_op(3'b001, 32'd1, 32'd31, 0, 1'b0);                // SLL, 32 cycles
    run_op(3'b101, 32'h8000_0000, 32'd4, 0, 1'b0);         // SRL, 5 cycles
    run_op(3'b001, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 1'b0); // shamt=0 (upper bits ignored)
    run_op(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5, 1'b0); // backpressure
    run_op(3'b011, 32'd3, 32'd4, 0, 1'b0);                 // illegal
    run_op(3'b001, 32'h0000_00F3, 32'd12, 0, 1'b1);        // operands changed mid-shift
    run_op(3'b101, 32'hFFFF_FFFF, 32'd31, 1, 1'b1);

    // Reset pulsed mid-shift (SLL by 20, at cycle 8)
    bus.in_valid    = 1'b1;
    bus.alu_control = 3'b001;
    bus.src_a       = 32'h0000_0ABC;
    bus.src_b       = 32'd20;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    check("midrst_result", bus.result, 32'd0);
    check("midrst_zero", {31'd0, bus.zero}, 32'd0);
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("postrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    stale = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.out_valid) stale++;
      step();
    end
    check("postrst_stale_valid", stale, 0);

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;   // encourage zero results
      run_op(op, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
